// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - segment constants and sizing helper for the BCD display scanner
// Exports active-high {g,f,e,d,c,b,a} patterns for digits 0..9, a dash for
// non-BCD codes, an all-off pattern, and the digit-index width helper.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int DEFAULT_DIGITS = 4;

    // Digit index width: $clog2(DIGITS), never narrower than one bit.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_DIGITS);

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to 7-segment decoder
// Ports:
//   nibble in  4  BCD code; 10..15 decode to a dash
//   blank  in  1  1: all segments off regardless of nibble
//   seg    out 7  active-high {g,f,e,d,c,b,a}
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - tear-free capture and multiplexed scan of cascaded BCD counters
// Ports:
//   clk       in  1         system clock, rising edge
//   rst       in  1         synchronous active-high reset
//   bcd_in    in  4*DIGITS  nibble i = bits [4i+3:4i], digit 0 least significant
//   load      in  1         one-cycle strobe capturing bcd_in
//   blank_lz  in  1         1: blank leading zeros (digit 0 never blanked)
//   seg_o     out 7         {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   an_o      out DIGITS    one-hot digit enable, polarity per ACTIVE_LOW
//   invalid_o out 1         some displayed nibble is above 9
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  invalid_o
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    // XOR masks: all-ones flips active-high patterns to active-low, and
    // doubles as the "everything off" reset value.
    localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]    prescaler;
    logic                tick;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic [4*DIGITS-1:0] pending;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] shadow_next;
    logic [3:0]          cur_nibble;
    logic [DIGITS-1:0]   lz_mask;
    logic                all_zero;
    logic                any_invalid;
    logic                cur_blank;
    logic [6:0]          seg_raw;

    assign tick     = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

    // A load landing on the tick edge bypasses pending so the new value is
    // shown from this digit on rather than one full digit period later.
    assign shadow_next = load ? bcd_in : pending;
    assign cur_nibble  = shadow_next[{idx_next, 2'b00} +: 4];

    // Walk from the most significant digit down; a digit is a leading zero
    // while every nibble from it upward is zero. Digit 0 is always shown.
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (shadow_next[4*i +: 4] == 4'd0);
            lz_mask[i] = all_zero & (i != 0);
        end
    end

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid | (shadow[4*i +: 4] > 4'd9);
        end
    end

    assign cur_blank = blank_lz & lz_mask[idx_next];

    bcd_to_7seg u_dec (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (seg_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= IDX_W'(DIGITS - 1);
            pending   <= '0;
            shadow    <= '0;
            seg_o     <= SEG_POL;
            an_o      <= AN_POL;
            invalid_o <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            invalid_o <= any_invalid;
            if (load) begin
                pending <= bcd_in;
            end
            if (tick) begin
                idx    <= idx_next;
                shadow <= shadow_next;
                seg_o  <= seg_raw ^ SEG_POL;
                an_o   <= (DIGITS'(1) << idx_next) ^ AN_POL;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        invalid_o;

    int tests_run = 0;
    int tests_failed = 0;
    int e = 0;

    bcd_display_scanner #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg_o     (seg_o),
        .an_o      (an_o),
        .invalid_o (invalid_o)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(negedge clk);
        e++;
    endtask

    // Ticks land on every 4th edge after reset release.
    task automatic next_tick();
        do adv(); while (e % 4 != 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        check({tag, "_an"}, 32'(an_o), 32'(an_exp));
        check({tag, "_seg"}, 32'(seg_o), 32'(seg_exp));
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        adv();
        load   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bcd_in = '0; load = 1'b0; blank_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_disp("reset", 4'hF, 7'h7F);
        check("reset_inv", 32'(invalid_o), 32'h0);
        rst = 1'b0;
        e = 0;

        // 1. dark until the first tick, then digit 0
        adv(); check_disp("pre_tick1", 4'hF, 7'h7F);
        adv(); check_disp("pre_tick2", 4'hF, 7'h7F);
        adv(); check_disp("pre_tick3", 4'hF, 7'h7F);
        adv(); check_disp("first_tick", 4'hE, 7'h40);

        // 2. 1234 without blanking (idx currently 0)
        do_load(16'h1234);
        next_tick(); check_disp("v1234_d1", 4'hD, 7'h30);
        adv();       check_disp("v1234_d1_hold", 4'hD, 7'h30);
        next_tick(); check_disp("v1234_d2", 4'hB, 7'h24);
        next_tick(); check_disp("v1234_d3", 4'h7, 7'h79);
        next_tick(); check_disp("v1234_d0", 4'hE, 7'h19);
        next_tick(); check_disp("v1234_wrap_d1", 4'hD, 7'h30);
        check("v1234_inv", 32'(invalid_o), 32'h0);

        // 3. leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0009);
        next_tick(); check_disp("v0009_d2", 4'hB, 7'h7F);
        next_tick(); check_disp("v0009_d3", 4'h7, 7'h7F);
        next_tick(); check_disp("v0009_d0", 4'hE, 7'h10);
        next_tick(); check_disp("v0009_d1", 4'hD, 7'h7F);
        do_load(16'h0900);
        next_tick(); check_disp("v0900_d2", 4'hB, 7'h10);
        next_tick(); check_disp("v0900_d3", 4'h7, 7'h7F);
        next_tick(); check_disp("v0900_d0", 4'hE, 7'h40);
        next_tick(); check_disp("v0900_d1", 4'hD, 7'h40);

        // 4. invalid code
        do_load(16'h00A0);
        next_tick(); check_disp("v00A0_d2", 4'hB, 7'h7F);
        check("inv_lag", 32'(invalid_o), 32'h0);
        adv();       check("inv_set", 32'(invalid_o), 32'h1);
        next_tick(); check_disp("v00A0_d3", 4'h7, 7'h7F);
        next_tick(); check_disp("v00A0_d0", 4'hE, 7'h40);
        next_tick(); check_disp("v00A0_d1_dash", 4'hD, 7'h3F);
        do_load(16'h0000);
        next_tick(); check_disp("v0000_d2", 4'hB, 7'h7F);
        check("inv_hold", 32'(invalid_o), 32'h1);
        adv();       check("inv_clear", 32'(invalid_o), 32'h0);

        // 5. load coincident with tick (e=77, tick at e=80)
        blank_lz = 1'b0;
        do_load(16'h5555);
        check_disp("old_hold1", 4'hB, 7'h7F);
        adv();
        check_disp("old_hold2", 4'hB, 7'h7F);
        do_load(16'h6666);
        check("coinc_phase", 32'(e % 4), 32'h0);
        check_disp("coinc_d3", 4'h7, 7'h02);
        adv();       check_disp("coinc_hold", 4'h7, 7'h02);
        next_tick(); check_disp("coinc_d0", 4'hE, 7'h02);

        // 6. reset mid-digit
        do_load(16'h1234);
        next_tick(); check_disp("pre_rst_d1", 4'hD, 7'h30);
        adv();
        rst = 1'b1;
        adv();
        check_disp("mid_rst", 4'hF, 7'h7F);
        check("mid_rst_inv", 32'(invalid_o), 32'h0);
        rst = 1'b0;
        e = 0;
        adv(); adv(); adv();
        check_disp("post_rst_dark", 4'hF, 7'h7F);
        adv();
        check_disp("post_rst_d0", 4'hE, 7'h40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
